// File: rtl/tftp_field_decode.sv
// ============================================================================
// Module   : tftp_field_decode
// Purpose  : Skips SKIP_BYTES of a frame, then captures a big-endian
//            FIELD_BYTES-wide field; optional compare under FIELD_CMP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tftp_field_decode #(
    parameter int FIELD_BYTES = 2,
    parameter int SKIP_BYTES  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     en,
    input  logic [7:0]               eth_data,
    input  logic                     frame_end,
    output logic [8*FIELD_BYTES-1:0] field_value,
    output logic                     field_valid,
    output logic                     field_done,
    output logic                     field_short
`ifdef FIELD_CMP_EN
    ,
    input  logic [8*FIELD_BYTES-1:0] expect_value,
    output logic                     field_match
`endif
);

    localparam int C_FW   = 8 * FIELD_BYTES;
    localparam int C_MAXB = (SKIP_BYTES > FIELD_BYTES) ? SKIP_BYTES : FIELD_BYTES;
    localparam int C_CW   = $clog2(C_MAXB + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SKIP    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [1:0] S_INIT    = (SKIP_BYTES > 0) ? S_SKIP : S_CAPTURE;

    logic [1:0]      r_state, w_state_next;
    logic [C_CW-1:0] r_cnt, w_cnt_next;
    logic [C_FW-1:0] r_value, w_value_next;
    logic            r_valid, w_valid_next;
    logic            r_done, w_done_next;
    logic            r_short, w_short_next;
    logic            r_match, w_match_next;

    // start restarts the frame first; the coincident en byte then acts on the fresh context
    logic [1:0]      w_cur_state;
    logic [C_CW-1:0] w_cur_cnt;
    logic [C_FW-1:0] w_cur_value;
    logic            w_byte_done;
    logic            w_short;

    assign w_cur_state = start ? S_INIT : r_state;
    assign w_cur_cnt   = start ? '0 : r_cnt;
    assign w_cur_value = start ? '0 : r_value;
    assign w_byte_done = (w_cur_state == S_CAPTURE) && en &&
                         (w_cur_cnt == C_CW'(FIELD_BYTES - 1));
    assign w_short     = !start && frame_end && !w_byte_done &&
                         ((r_state == S_SKIP) || (r_state == S_CAPTURE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_value <= w_value_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            r_short <= w_short_next;
            r_match <= w_match_next;
        end
    end

    always_comb begin
        w_state_next = w_cur_state;
        w_cnt_next   = w_cur_cnt;
        case (w_cur_state)
            S_SKIP: begin
                if (en) begin
                    if (w_cur_cnt == C_CW'(SKIP_BYTES - 1)) begin
                        w_state_next = S_CAPTURE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cur_cnt + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (w_byte_done) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else if (en) begin
                    w_cnt_next = w_cur_cnt + 1'b1;
                end
            end
            default: ;
        endcase
        if (w_short) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end
    end

    always_comb begin
        w_value_next = w_cur_value;
        w_valid_next = start ? 1'b0 : r_valid;
        w_done_next  = 1'b0;
        w_short_next = w_short;
        w_match_next = start ? 1'b0 : r_match;
        if ((w_cur_state == S_CAPTURE) && en)
            w_value_next = (w_cur_value << 8) | C_FW'(eth_data);
        if (w_byte_done) begin
            w_valid_next = 1'b1;
            w_done_next  = 1'b1;
`ifdef FIELD_CMP_EN
            w_match_next = (w_value_next == expect_value);
`endif
        end
        if (w_short) begin
            w_value_next = '0;
            w_match_next = 1'b0;
        end
    end

    assign field_value = r_value;
    assign field_valid = r_valid;
    assign field_done  = r_done;
    assign field_short = r_short;
`ifdef FIELD_CMP_EN
    assign field_match = r_match;
`else
    logic w_unused;
    assign w_unused = r_match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tftp_field_decode.sv
// ============================================================================
// Module   : tb_tftp_field_decode
// Purpose  : Directed checks of tftp_field_decode in three parameter sets.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tftp_field_decode;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [7:0] eth_data = 8'h00;
    logic       frame_end = 1'b0;

    logic [15:0] a_value, b_value;
    logic [31:0] c_value;
    logic        a_valid, a_done, a_short;
    logic        b_valid, b_done, b_short;
    logic        c_valid, c_done, c_short;
    logic [15:0] b_expect = 16'h0007;
    logic        a_match, b_match, c_match;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tftp_field_decode #(.FIELD_BYTES(2), .SKIP_BYTES(2)) u_a (
        .clk(clk), .reset(reset), .start(start), .en(en), .eth_data(eth_data),
        .frame_end(frame_end), .field_value(a_value), .field_valid(a_valid),
        .field_done(a_done), .field_short(a_short)
`ifdef FIELD_CMP_EN
        , .expect_value(16'h0000), .field_match(a_match)
`endif
    );

    tftp_field_decode #(.FIELD_BYTES(2), .SKIP_BYTES(0)) u_b (
        .clk(clk), .reset(reset), .start(start), .en(en), .eth_data(eth_data),
        .frame_end(frame_end), .field_value(b_value), .field_valid(b_valid),
        .field_done(b_done), .field_short(b_short)
`ifdef FIELD_CMP_EN
        , .expect_value(b_expect), .field_match(b_match)
`endif
    );

    tftp_field_decode #(.FIELD_BYTES(4), .SKIP_BYTES(0)) u_c (
        .clk(clk), .reset(reset), .start(start), .en(en), .eth_data(eth_data),
        .frame_end(frame_end), .field_value(c_value), .field_valid(c_valid),
        .field_done(c_done), .field_short(c_short)
`ifdef FIELD_CMP_EN
        , .expect_value(32'h0), .field_match(c_match)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the sampling edge
    task automatic cyc(input logic st, input logic e, input logic [7:0] d, input logic fe);
        @(negedge clk);
        start     = st;
        en        = e;
        eth_data  = d;
        frame_end = fe;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", 64'(a_value), 64'h0);
        check("rst_valid", 64'(a_valid), 64'h0);
        check("rst_done",  64'(a_done),  64'h0);
        check("rst_short", 64'(a_short), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Skip two header bytes, capture 0x1234 with a gap mid-field
        cyc(1, 1, 8'h00, 0);
        cyc(0, 1, 8'h03, 0);
        check("skip_value", 64'(a_value), 64'h0);
        cyc(0, 1, 8'h12, 0);
        cyc(0, 0, 8'h99, 0);
        check("gap_partial", 64'(a_value), 64'h0012);
        check("gap_valid",   64'(a_valid), 64'h0);
        cyc(0, 1, 8'h34, 0);
        check("t1_value", 64'(a_value), 64'h1234);
        check("t1_valid", 64'(a_valid), 64'h1);
        check("t1_done",  64'(a_done),  64'h1);
        cyc(0, 1, 8'hFF, 0);
        check("t1_done_pulse", 64'(a_done), 64'h0);
        check("t1_hold1", 64'(a_value), 64'h1234);
        cyc(0, 1, 8'hFF, 0);
        check("t1_hold2", 64'(a_value), 64'h1234);
        check("t1_hold_valid", 64'(a_valid), 64'h1);

        // Frame ends before the field completes
        cyc(1, 1, 8'h00, 0);
        check("t2_start_clr", 64'(a_valid), 64'h0);
        cyc(0, 1, 8'h03, 0);
        cyc(0, 1, 8'h12, 0);
        cyc(0, 0, 8'h00, 1);
        check("t2_short", 64'(a_short), 64'h1);
        check("t2_value", 64'(a_value), 64'h0);
        check("t2_valid", 64'(a_valid), 64'h0);
        check("t2_done",  64'(a_done),  64'h0);
        cyc(0, 0, 8'h00, 0);
        check("t2_short_pulse", 64'(a_short), 64'h0);
        cyc(0, 0, 8'h00, 1);
        check("t2_idle_fe", 64'(a_short), 64'h0);

        // Last byte coincident with frame_end completes the field
        cyc(1, 1, 8'h12, 0);
        check("t3_partial", 64'(b_valid), 64'h0);
        cyc(0, 1, 8'h34, 1);
        check("t3_value", 64'(b_value), 64'h1234);
        check("t3_done",  64'(b_done),  64'h1);
        check("t3_short", 64'(b_short), 64'h0);
        cyc(0, 0, 8'h00, 0);
        check("t3_done_pulse", 64'(b_done),  64'h0);
        check("t3_short_late", 64'(b_short), 64'h0);
        check("t3_valid",      64'(b_valid), 64'h1);
        cyc(0, 0, 8'h00, 1);
        check("t3_done_fe", 64'(b_short), 64'h0);

        // Restart mid-capture of a 4-byte field
        cyc(1, 1, 8'hDE, 0);
        cyc(0, 1, 8'hAD, 0);
        check("t4_partial", 64'(c_value), 64'h0000DEAD);
        cyc(1, 1, 8'h01, 0);
        check("t4_restart", 64'(c_value), 64'h00000001);
        cyc(0, 1, 8'h02, 0);
        cyc(0, 1, 8'h03, 0);
        check("t4_not_done", 64'(c_done), 64'h0);
        cyc(0, 1, 8'h04, 0);
        check("t4_value", 64'(c_value), 64'h01020304);
        check("t4_done",  64'(c_done),  64'h1);
        cyc(0, 0, 8'h00, 0);
        check("t4_done_pulse", 64'(c_done), 64'h0);

        // Asynchronous reset mid-capture
        cyc(1, 1, 8'hAB, 0);
        check("t5_partial", 64'(b_value), 64'h00AB);
        @(negedge clk);
        start = 1'b0;
        en    = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_value", 64'(b_value), 64'h0);
        check("t5_rst_valid", 64'(b_valid), 64'h0);
        check("t5_rst_done",  64'(b_done),  64'h0);
        check("t5_rst_short", 64'(b_short), 64'h0);
        #1;
        reset = 1'b0;
        cyc(1, 1, 8'h00, 0);
        cyc(0, 1, 8'h05, 0);
        check("t5_value", 64'(b_value), 64'h0005);
        check("t5_done",  64'(b_done),  64'h1);

`ifdef FIELD_CMP_EN
        cyc(1, 1, 8'h00, 0);
        cyc(0, 1, 8'h07, 0);
        check("cmp_match", 64'(b_match), 64'h1);
        cyc(1, 1, 8'h00, 0);
        check("cmp_start_clr", 64'(b_match), 64'h0);
        cyc(0, 1, 8'h08, 0);
        check("cmp_nomatch", 64'(b_match), 64'h0);
        check("cmp_value", 64'(b_value), 64'h0008);
`endif

        cyc(0, 0, 8'h00, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
